intr_entry_ctrl: RTL and testbench

INTR_ENTRY_CTRL -- requirements
Module: intr_entry_ctrl

---
 rtl/intr_entry_ctrl.sv | 161 ++++++++++++++++
 tb/tb_intr_entry_ctrl.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intr_entry_ctrl.sv
// intr_entry_ctrl
//
// Sequences entry into an exception handler and the return from it.
// An exception is first drained from the pipeline. The controller then saves
// the return PC and MSR into SRR0/SRR1. Finally it vectors to the handler
// with a masked MSR and an aligned entry address. A return-from-interrupt
// restores MSR and PC from SRR1/SRR0 in a single cycle.
//
// Ports
//   clk            single clock, rising edge
//   rst            synchronous active-low reset
//   excepCode      pending exception code (0 = none)
//   intrEntryAddr  handler vector address
//   ack            one-cycle acknowledge when the handler is entered
//   curPC, nextPC  oldest in-flight instruction address and its successor
//   MSR, SRR0/1    current machine state and save/restore register values
//   flush_req      pipeline drain request
//   stall          fetch stall while a sequence is in progress
//   drained        pipeline reports empty
//   rfi_req        return-from-interrupt request
//   rfi_done       one-cycle completion of a return-from-interrupt
//   *_wr/*_wd      one-cycle write strobes and data for SRR0, SRR1, MSR, NPC

`ifndef ExcepCode_WIDTH
`define ExcepCode_WIDTH 4
`endif
`ifndef ExcepCode_EXT
`define ExcepCode_EXT 4'd1
`endif
`ifndef ExcepCode_SC
`define ExcepCode_SC 4'd8
`endif

module intr_entry_ctrl (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [`ExcepCode_WIDTH-1:0]  excepCode,
    input  logic [0:31]                  intrEntryAddr,
    output logic                         ack,
    input  logic [0:31]                  curPC,
    input  logic [0:31]                  nextPC,
    input  logic [0:31]                  MSR,
    input  logic [0:31]                  SRR0,
    input  logic [0:31]                  SRR1,
    output logic                         flush_req,
    output logic                         stall,
    input  logic                         drained,
    input  logic                         rfi_req,
    output logic                         rfi_done,
    output logic                         SRR0_wr,
    output logic [0:31]                  SRR0_wd,
    output logic                         SRR1_wr,
    output logic [0:31]                  SRR1_wd,
    output logic                         MSR_wr,
    output logic [0:31]                  MSR_wd,
    output logic                         NPC_wr,
    output logic [0:31]                  NPC_wd
);

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        SAVE,
        VECTOR,
        RFI
    } state_t;

    // MSR bits 16 (EE), 17 (PR), 26 (IS) and 27 (DS) in big-endian numbering.
    localparam logic [0:31] MSR_CLEAR_MASK = 32'h0000_C030;
    localparam logic [0:31] NPC_ALIGN_MASK = 32'hFFFF_FFF0;
    localparam logic [0:31] RFI_ALIGN_MASK = 32'hFFFF_FFFC;

    state_t                        state_q;
    state_t                        state_d;
    logic [`ExcepCode_WIDTH-1:0]   code_q;

    // The code is latched only on the IDLE->DRAIN edge, so later changes of
    // excepCode cannot alter which return PC is saved.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && excepCode != '0) begin
                code_q <= excepCode;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ack       = 1'b0;
        flush_req = 1'b0;
        stall     = 1'b0;
        rfi_done  = 1'b0;
        SRR0_wr   = 1'b0;
        SRR0_wd   = '0;
        SRR1_wr   = 1'b0;
        SRR1_wd   = '0;
        MSR_wr    = 1'b0;
        MSR_wd    = '0;
        NPC_wr    = 1'b0;
        NPC_wd    = '0;

        case (state_q)
            IDLE: begin
                // Exceptions take priority; a simultaneous rfi_req is picked
                // up again the next time IDLE is reached.
                if (excepCode != '0) begin
                    state_d = DRAIN;
                end else if (rfi_req) begin
                    state_d = RFI;
                end
            end

            DRAIN: begin
                flush_req = 1'b1;
                stall     = 1'b1;
                if (drained) begin
                    state_d = SAVE;
                end
            end

            SAVE: begin
                // A system call returns past the sc instruction itself.
                stall   = 1'b1;
                SRR0_wr = 1'b1;
                SRR0_wd = (code_q == `ExcepCode_SC) ? nextPC : curPC;
                SRR1_wr = 1'b1;
                SRR1_wd = MSR;
                state_d = VECTOR;
            end

            VECTOR: begin
                stall   = 1'b1;
                ack     = 1'b1;
                MSR_wr  = 1'b1;
                MSR_wd  = MSR & ~MSR_CLEAR_MASK;
                NPC_wr  = 1'b1;
                NPC_wd  = intrEntryAddr & NPC_ALIGN_MASK;
                state_d = IDLE;
            end

            RFI: begin
                stall    = 1'b1;
                rfi_done = 1'b1;
                MSR_wr   = 1'b1;
                MSR_wd   = SRR1;
                NPC_wr   = 1'b1;
                NPC_wd   = SRR0 & RFI_ALIGN_MASK;
                state_d  = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_intr_entry_ctrl.sv
// tb_intr_entry_ctrl
//
// Directed bench for intr_entry_ctrl. A transaction-level model predicts the
// outputs every cycle: a drain-wait flag plus a queue of pending single-cycle
// actions. A few scenario results are also pinned to hand-computed literals.

module tb_intr_entry_ctrl;

    localparam logic [3:0] EXC_EXT = 4'd1;
    localparam logic [3:0] EXC_SC  = 4'd8;

    logic        clk;
    logic        rst;
    logic [3:0]  excepCode;
    logic [31:0] intrEntryAddr;
    logic        ack;
    logic [31:0] curPC;
    logic [31:0] nextPC;
    logic [31:0] MSR;
    logic [31:0] SRR0;
    logic [31:0] SRR1;
    logic        flush_req;
    logic        stall;
    logic        drained;
    logic        rfi_req;
    logic        rfi_done;
    logic        SRR0_wr;
    logic [31:0] SRR0_wd;
    logic        SRR1_wr;
    logic [31:0] SRR1_wd;
    logic        MSR_wr;
    logic [31:0] MSR_wd;
    logic        NPC_wr;
    logic [31:0] NPC_wd;

    intr_entry_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .excepCode     (excepCode),
        .intrEntryAddr (intrEntryAddr),
        .ack           (ack),
        .curPC         (curPC),
        .nextPC        (nextPC),
        .MSR           (MSR),
        .SRR0          (SRR0),
        .SRR1          (SRR1),
        .flush_req     (flush_req),
        .stall         (stall),
        .drained       (drained),
        .rfi_req       (rfi_req),
        .rfi_done      (rfi_done),
        .SRR0_wr       (SRR0_wr),
        .SRR0_wd       (SRR0_wd),
        .SRR1_wr       (SRR1_wr),
        .SRR1_wd       (SRR1_wd),
        .MSR_wr        (MSR_wr),
        .MSR_wd        (MSR_wd),
        .NPC_wr        (NPC_wr),
        .NPC_wd        (NPC_wd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        ack;
        logic        flush_req;
        logic        stall;
        logic        rfi_done;
        logic        srr0_wr;
        logic [31:0] srr0_wd;
        logic        srr1_wr;
        logic [31:0] srr1_wd;
        logic        msr_wr;
        logic [31:0] msr_wd;
        logic        npc_wr;
        logic [31:0] npc_wd;
    } out_t;

    typedef enum {A_SAVE, A_VECTOR, A_RFI} act_e;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit cmp_en = 1'b0;

    // Model state: waiting for the pipeline to drain, the latched code, and
    // the queue of single-cycle actions still to be performed.
    bit         m_wait = 1'b0;
    logic [3:0] m_code = '0;
    act_e       m_q[$];

    // Event captures observed on the DUT outputs.
    int          ack_cnt = 0, rfi_cnt = 0, srr0_cnt = 0, flush_cnt = 0;
    int          ack_cyc = 0, rfi_cyc = 0;
    logic [31:0] cap_srr0 = '0, cap_srr1 = '0, cap_vmsr = '0, cap_vnpc = '0;
    logic [31:0] cap_rmsr = '0, cap_rnpc = '0;

    // Single bit n of a 32-bit value in big-endian (bit 0 = MSB) numbering.
    function automatic logic [31:0] be_bit(input int n);
        return 32'h1 << (31 - n);
    endfunction

    function automatic out_t model_out();
        out_t o;
        o = '0;
        if (m_wait) begin
            o.flush_req = 1'b1;
            o.stall     = 1'b1;
        end else if (m_q.size() > 0) begin
            o.stall = 1'b1;
            case (m_q[0])
                A_SAVE: begin
                    o.srr0_wr = 1'b1;
                    o.srr0_wd = (m_code == EXC_SC) ? nextPC : curPC;
                    o.srr1_wr = 1'b1;
                    o.srr1_wd = MSR;
                end
                A_VECTOR: begin
                    o.ack    = 1'b1;
                    o.msr_wr = 1'b1;
                    o.msr_wd = MSR & ~(be_bit(16) | be_bit(17) | be_bit(26) | be_bit(27));
                    o.npc_wr = 1'b1;
                    o.npc_wd = {intrEntryAddr[31:4], 4'h0};
                end
                default: begin
                    o.rfi_done = 1'b1;
                    o.msr_wr   = 1'b1;
                    o.msr_wd   = SRR1;
                    o.npc_wr   = 1'b1;
                    o.npc_wd   = {SRR0[31:2], 2'b00};
                end
            endcase
        end
        return o;
    endfunction

    // Advance the model on each rising edge using the inputs held across it.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            m_wait = 1'b0;
            m_code = '0;
            m_q.delete();
        end else if (m_wait) begin
            if (drained) begin
                m_wait = 1'b0;
                m_q.push_back(A_SAVE);
                m_q.push_back(A_VECTOR);
            end
        end else if (m_q.size() > 0) begin
            void'(m_q.pop_front());
        end else if (excepCode != 4'd0) begin
            m_code = excepCode;
            m_wait = 1'b1;
        end else if (rfi_req) begin
            m_q.push_back(A_RFI);
        end
    end

    // Per-cycle comparison of every output against the model, then capture
    // of the events the directed scenarios inspect.
    always @(negedge clk) begin
        out_t exp_o;
        out_t act_o;
        #2;
        if (cmp_en) begin
            exp_o = model_out();
            act_o = '{ack, flush_req, stall, rfi_done, SRR0_wr, SRR0_wd, SRR1_wr,
                      SRR1_wd, MSR_wr, MSR_wd, NPC_wr, NPC_wd};
            n_cmp++;
            if (act_o !== exp_o) begin
                n_fail++;
                $display("[TB] FAIL outputs cyc=%0d got=%h expected=%h", cyc, act_o, exp_o);
            end
            if (SRR0_wr) begin
                srr0_cnt++;
                cap_srr0 = SRR0_wd;
                cap_srr1 = SRR1_wd;
            end
            if (ack) begin
                ack_cnt++;
                ack_cyc  = cyc;
                cap_vmsr = MSR_wd;
                cap_vnpc = NPC_wd;
            end
            if (rfi_done) begin
                rfi_cnt++;
                rfi_cyc  = cyc;
                cap_rmsr = MSR_wd;
                cap_rnpc = NPC_wd;
            end
            if (flush_req) flush_cnt++;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("[TB] FAIL %s got=%h expected=%h", name, got, want);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] code, input logic rfi, input logic drn);
        @(negedge clk);
        excepCode = code;
        rfi_req   = rfi;
        drained   = drn;
    endtask

    task automatic setRegs(input logic [31:0] cur, input logic [31:0] nxt, input logic [31:0] msr,
                           input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] entry);
        curPC         = cur;
        nextPC        = nxt;
        MSR           = msr;
        SRR0          = s0;
        SRR1          = s1;
        intrEntryAddr = entry;
    endtask

    // Waits for the next ack (want_rfi = 0) or rfi_done (want_rfi = 1), ending
    // just after the capture in the cycle where it appeared.
    task automatic waitFor(input bit want_rfi, input int budget);
        int base;
        int n;
        base = want_rfi ? rfi_cnt : ack_cnt;
        n    = 0;
        while (((want_rfi ? rfi_cnt : ack_cnt) == base) && n < budget) begin
            @(negedge clk);
            #3;
            n++;
        end
        n_cmp++;
        if ((want_rfi ? rfi_cnt : ack_cnt) == base) begin
            n_fail++;
            $display("[TB] FAIL %s_timeout got=none expected=event within %0d cycles",
                     want_rfi ? "rfi_done" : "ack", budget);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=no finish expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int start_cyc;
        int base_ack, base_rfi, base_flush, base_srr0;

        rst = 1'b0;
        excepCode = '0;
        rfi_req = 1'b0;
        drained = 1'b0;
        setRegs(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        cmp_en = 1'b1;
        @(negedge clk);
        #3;
        checkOutput("reset_ack_count", ack_cnt, 0);
        rst = 1'b1;

        // External interrupt with the pipeline already empty.
        setRegs(32'h100, 32'h104, 32'h0002_C000, 32'h0, 32'h0, 32'h0000_0503);
        applyStimulus(EXC_EXT, 1'b0, 1'b1);
        start_cyc = cyc;
        base_ack  = ack_cnt;
        waitFor(1'b0, 10);
        excepCode = '0;
        checkOutput("ext_ack_cycle", ack_cyc - start_cyc + 1, 4);
        checkOutput("ext_srr0", cap_srr0, 32'h100);
        checkOutput("ext_srr1", cap_srr1, 32'h0002_C000);
        checkOutput("ext_msr_wd", cap_vmsr, 32'h0002_0000);
        checkOutput("ext_npc_wd", cap_vnpc, 32'h500);
        repeat (3) @(negedge clk);
        checkOutput("ext_ack_count", ack_cnt - base_ack, 1);

        // System call saves the following instruction address.
        setRegs(32'h200, 32'h204, 32'h0000_8000, 32'h0, 32'h0, 32'h0000_0C00);
        base_ack = ack_cnt;
        applyStimulus(EXC_SC, 1'b0, 1'b1);
        waitFor(1'b0, 10);
        excepCode = '0;
        checkOutput("sc_srr0", cap_srr0, 32'h204);
        repeat (3) @(negedge clk);
        checkOutput("sc_ack_count", ack_cnt - base_ack, 1);

        // Long drain while excepCode changes; the first code must be used.
        setRegs(32'h300, 32'h304, 32'h0000_0030, 32'h0, 32'h0, 32'h0000_0700);
        base_ack   = ack_cnt;
        base_flush = flush_cnt;
        applyStimulus(EXC_EXT, 1'b0, 1'b0);
        @(negedge clk);
        excepCode = EXC_SC;
        repeat (9) @(negedge clk);
        drained   = 1'b1;
        excepCode = '0;
        waitFor(1'b0, 10);
        checkOutput("drain_flush_cycles", flush_cnt - base_flush, 10);
        checkOutput("drain_srr0", cap_srr0, 32'h300);
        repeat (3) @(negedge clk);
        checkOutput("drain_ack_count", ack_cnt - base_ack, 1);

        // Return from interrupt.
        setRegs(32'h0, 32'h0, 32'h0, 32'h307, 32'h8000, 32'h0);
        base_rfi = rfi_cnt;
        applyStimulus(4'd0, 1'b1, 1'b1);
        waitFor(1'b1, 10);
        rfi_req = 1'b0;
        checkOutput("rfi_msr_wd", cap_rmsr, 32'h8000);
        checkOutput("rfi_npc_wd", cap_rnpc, 32'h304);
        repeat (3) @(negedge clk);
        checkOutput("rfi_done_count", rfi_cnt - base_rfi, 1);

        // Exception and rfi_req together: exception first, then the return.
        setRegs(32'h500, 32'h504, 32'h0000_4000, 32'h60B, 32'h10, 32'h0000_0900);
        base_ack = ack_cnt;
        base_rfi = rfi_cnt;
        applyStimulus(EXC_EXT, 1'b1, 1'b1);
        @(negedge clk);
        excepCode = '0;
        waitFor(1'b0, 10);
        waitFor(1'b1, 10);
        rfi_req = 1'b0;
        checkOutput("both_order", ack_cyc < rfi_cyc, 1);
        repeat (3) @(negedge clk);
        checkOutput("both_ack_count", ack_cnt - base_ack, 1);
        checkOutput("both_rfi_count", rfi_cnt - base_rfi, 1);

        // Exception arriving during RFI is taken straight from IDLE.
        setRegs(32'h400, 32'h404, 32'h0, 32'h20, 32'h0, 32'h0000_0A00);
        applyStimulus(4'd0, 1'b1, 1'b1);
        waitFor(1'b1, 10);
        rfi_req   = 1'b0;
        excepCode = EXC_EXT;
        waitFor(1'b0, 10);
        excepCode = '0;
        checkOutput("rfi_then_exc_gap", ack_cyc - rfi_cyc, 4);
        checkOutput("rfi_then_exc_srr0", cap_srr0, 32'h400);

        // Reset during SAVE aborts; the still-pending exception restarts.
        repeat (2) @(negedge clk);
        setRegs(32'h600, 32'h604, 32'h0000_C000, 32'h0, 32'h0, 32'h0000_0B00);
        base_ack  = ack_cnt;
        base_srr0 = srr0_cnt;
        applyStimulus(EXC_EXT, 1'b0, 1'b0);
        @(negedge clk);
        drained = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        checkOutput("rst_abort_ack", ack_cnt - base_ack, 0);
        checkOutput("rst_abort_writes", srr0_cnt - base_srr0, 1);
        waitFor(1'b0, 12);
        excepCode = '0;
        checkOutput("rst_restart_vnpc", cap_vnpc, 32'h0000_0B00);
        repeat (3) @(negedge clk);
        checkOutput("rst_restart_ack", ack_cnt - base_ack, 1);
        checkOutput("rst_restart_writes", srr0_cnt - base_srr0, 2);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
